// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl
// ------------
// Micro-sequencer sitting in front of the A/B/OUT register bank. It takes one
// instruction at a time and runs it through IDLE -> (EXEC) -> WB -> IDLE.
// ALU instructions spend ALU_LAT cycles in EXEC while the ALU op is driven.
// WB lasts one cycle. In WB the controller raises at most one register write
// enable, drives the write data onto the shared bus and pulses done.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both 1. instr_ready is 1 only in IDLE (and while rst is
// high). While busy, the opcode/imm inputs are ignored and nothing is queued.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   instr_valid/ready instruction handshake
//   opcode, imm       instruction; imm[2:0] is the ALU op for ALU opcodes
//   A_reg, B_reg      current register values (read combinationally in WB)
//   alu_result        ALU output (read combinationally in WB)
//   alu_op            ALU operation select
//   C_in              shared write data bus to the register bank
//   write_a/b/o       one-cycle write enables for A, B and OUT
//   busy              instruction in flight (EXEC or WB)
//   done              one-cycle completion pulse in WB
//   err               sticky illegal-opcode flag, cleared only by rst
//   dbg_state_o       current FSM state (0 IDLE, 1 EXEC, 2 WB)
module reg_seq_ctrl #(
    parameter int ALU_LAT = 2,
    parameter int DW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [3:0]    opcode,
    input  logic [DW-1:0] imm,
    input  logic [DW-1:0] A_reg,
    input  logic [DW-1:0] B_reg,
    input  logic [DW-1:0] alu_result,
    output logic [2:0]    alu_op,
    output logic [DW-1:0] C_in,
    output logic          write_a,
    output logic          write_b,
    output logic          write_o,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDA  = 4'd1;
    localparam logic [3:0] OP_LDB  = 4'd2;
    localparam logic [3:0] OP_ALUA = 4'd3;
    localparam logic [3:0] OP_ALUO = 4'd4;
    localparam logic [3:0] OP_MOVA = 4'd5;
    localparam logic [3:0] OP_MOVB = 4'd6;

    localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] imm_q, imm_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            imm_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        imm_d       = imm_q;
        err_d       = err_q;
        instr_ready = 1'b0;
        busy        = 1'b0;
        alu_op      = 3'd0;
        C_in        = '0;
        write_a     = 1'b0;
        write_b     = 1'b0;
        write_o     = 1'b0;
        done        = 1'b0;

        if (rst) begin
            // Outputs are forced quiet while reset is held, whatever the
            // state register still contains.
            instr_ready = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        op_d  = opcode;
                        imm_d = imm;
                        if (opcode == OP_ALUA || opcode == OP_ALUO) begin
                            state_d = ST_EXEC;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_EXEC: begin
                    busy   = 1'b1;
                    alu_op = imm_q[2:0];
                    if (cnt_q == 4'd0) begin
                        state_d = ST_WB;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_WB: begin
                    busy    = 1'b1;
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    case (op_q)
                        OP_NOP: ;
                        OP_LDA: begin
                            write_a = 1'b1;
                            C_in    = imm_q;
                        end
                        OP_LDB: begin
                            write_b = 1'b1;
                            C_in    = imm_q;
                        end
                        OP_ALUA: begin
                            // ALU op is held from EXEC so alu_result stays valid.
                            alu_op  = imm_q[2:0];
                            write_a = 1'b1;
                            C_in    = alu_result;
                        end
                        OP_ALUO: begin
                            alu_op  = imm_q[2:0];
                            write_o = 1'b1;
                            C_in    = alu_result;
                        end
                        OP_MOVA: begin
                            write_o = 1'b1;
                            C_in    = A_reg;
                        end
                        OP_MOVB: begin
                            write_o = 1'b1;
                            C_in    = B_reg;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule
